// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin burst arbiter:
// fixed sizes, FSM encoding, output-stage beat record and pointer helper.
package arb_pkg;

    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              vld;
        logic              last;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } out_beat_t;

    // Round-robin pointer advance; wraps 3 -> 0 via the 2-bit width.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/bit32_4to1mux.sv
// Shared 32-bit 4:1 payload mux used by several datapaths.
module bit32_4to1mux (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [1:0]  sel,
    output logic [31:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand;

    // Scan farthest offset first so the closest hit to ptr is the one kept.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        cand   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_burst_arb4.sv
// Four-requester round-robin arbiter with burst lock and a single registered
// valid/ready output stage feeding one shared consumer.
module rr_burst_arb4
    import arb_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,   // fixed at 32 by the shared mux
    parameter int N_REQ_P  = N_REQ     // fixed at 4; grant index is 2 bits
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [DATA_W-1:0]   req_data0,
    input  logic [DATA_W-1:0]   req_data1,
    input  logic [DATA_W-1:0]   req_data2,
    input  logic [DATA_W-1:0]   req_data3,
    output logic [N_REQ-1:0]    req_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [SEL_W-1:0]    out_sel,
    output logic                out_last,
    input  logic                out_ready
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;

    logic             load_en;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;
    logic [SEL_W-1:0] grant;
    logic [N_REQ-1:0] ready_c;
    logic             xfer;
    logic             gnt_last;
    logic [DATA_W-1:0] mux_y;
    out_beat_t        beat_q;

    assign load_en = !beat_q.vld || out_ready;

    rr_pick4 u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Grant: picker result in IDLE, the burst owner while LOCKED.
    always_comb begin
        grant   = pick_idx;
        ready_c = '0;
        if (state_q == ST_IDLE) begin
            if (load_en && pick_any) ready_c = pick_onehot;
        end else begin
            grant = owner_q;
            if (load_en && req_valid[owner_q]) ready_c[owner_q] = 1'b1;
        end
    end

    assign req_ready = reset ? '0 : ready_c;
    assign xfer      = |ready_c;
    assign gnt_last  = req_last[grant];

    bit32_4to1mux u_mux (
        .in0 (req_data0),
        .in1 (req_data1),
        .in2 (req_data2),
        .in3 (req_data3),
        .sel (grant),
        .y   (mux_y)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (gnt_last) begin
                        rr_ptr_d = next_ptr(grant);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = grant;
                    end
                end
            end
            default: begin
                // An owner that stalls keeps the lock indefinitely.
                if (xfer && gnt_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr(owner_q);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q <= '0;
        end else if (xfer) begin
            beat_q.vld  <= 1'b1;
            beat_q.last <= gnt_last;
            beat_q.sel  <= grant;
            beat_q.data <= mux_y;
        end else if (out_ready) begin
            beat_q.vld <= 1'b0;
        end
    end

    assign out_valid = beat_q.vld;
    assign out_last  = beat_q.last;
    assign out_sel   = beat_q.sel;
    assign out_data  = beat_q.data;

endmodule

// File: doc/rr_burst_arb4.md
Name: rr_burst_arb4

Overview:
- Shares one 32-bit output channel between four requesters using round-robin arbitration.
- Supports multi-beat bursts: the grant is held from a burst's first beat until its beat with last=1.
- Steers data through the existing 32-bit 4:1 mux datapath (bit32_4to1mux), using the grant index as its select.
- Registers the result into a single output stage with a valid/ready handshake; sits between four producer blocks and one shared consumer.

Parameters:
- DATA_W, 32, payload width. Fixed at 32 to match bit32_4to1mux; any other value is illegal.
- N_REQ, 4, requester count. Fixed; the grant index is 2 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  4  per-requester valid
- req_last  in  4  per-requester last-beat flag, sampled with valid
- req_data0..req_data3  in  32 each  per-requester payload
- req_ready  out  4  per-requester accept, one-hot or zero
- out_valid  out  1  output stage holds a beat
- out_data  out  32  registered payload
- out_sel  out  2  index of the requester that produced out_data
- out_last  out  1  registered last flag
- out_ready  in  1  consumer accepts the output beat

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - state=IDLE, rr_ptr=0, owner=0.
  - req_ready is forced to 0 while reset is high.
- Load enable: load_en = !out_valid || out_ready. A beat transfers from requester i when req_valid[i] && req_ready[i].
- IDLE state:
  - If load_en and any req_valid bit is set, grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod 4. req_ready is asserted only for that requester.
  - On a transfer with req_last=1: stay in IDLE and set rr_ptr = grant+1 mod 4.
  - On a transfer with req_last=0: go to LOCKED with owner=grant.
  - With no requests, rr_ptr is unchanged.
- LOCKED state:
  - req_ready[owner] = load_en && req_valid[owner]; all other req_ready bits are 0.
  - On a transfer with req_last=1: go to IDLE and set rr_ptr = owner+1 mod 4.
  - If the owner drops valid mid-burst: stay LOCKED, load nothing, and issue no grant to others (no timeout).
- Output register:
  - On a transfer, out_data gets the mux output, out_sel gets the grant, out_last gets req_last[grant], and out_valid is set to 1. out_valid rises exactly one cycle after the accept edge.
  - If out_valid && out_ready and no transfer occurs, out_valid is cleared to 0.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Backpressure: out_valid && !out_ready gives load_en=0, so all req_ready=0 and out_* hold stable.
- Mux select: sel = grant index (0→data0 … 3→data3) drives bit32_4to1mux; the mux output feeds only the register.
- Combinational path: req_ready depends combinationally on req_valid and out_ready. Requesters must not derive valid from ready, and must hold valid/data/last stable until accepted.
- A single-beat burst is a beat with last=1 issued in IDLE.
- Reset mid-burst: LOCKED is abandoned and rr_ptr returns to 0. Any in-flight output beat is discarded.

Decomposition:
- Shared package arb_pkg holds:
  - localparams N_REQ=4, SEL_W=2, DATA_W=32
  - state encodings ST_IDLE=1'b0, ST_LOCKED=1'b1
- Sub-module rr_pick4 (combinational): inputs req[3:0] and ptr[1:0]; outputs any, idx[1:0] and onehot[3:0].
- Datapath reuses bit32_4to1mux; there is no new mux RTL.

Test Plan:
- Round-robin fairness:
  - Stimulus: reset, then req_valid=4'b1111 with all last=1 and out_ready=1 held, 8 cycles.
  - Response: out_sel sequence 0,1,2,3,0,1,2,3, with out_data equal to the respective inputs.
- Burst lock:
  - Stimulus: requester 2 sends 3 beats (last on the 3rd) while req_valid=4'b1111.
  - Response: out_sel=2,2,2, then 3; req_ready[0,1,3]=0 throughout the burst.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles with a beat held.
  - Response: out_valid=1; out_data/out_sel/out_last stable; req_ready=4'b0000. On release, 1 beat/cycle resumes with no loss or duplication.
- Owner stall:
  - Stimulus: requester 1 locked, drops valid for 3 cycles while 0, 2 and 3 are requesting.
  - Response: no grants during the stall; next output beat has out_sel=1.
- Skip idle and wrap:
  - Stimulus: rr_ptr=3, req_valid=4'b0010.
  - Response: grant 1, then rr_ptr=2.
- Async reset mid-burst:
  - Stimulus: reset pulse, not clock-aligned, during a LOCKED burst.
  - Response: out_valid=0 immediately; afterwards arbitration restarts from requester 0.
